alu_seq_core: RTL

Parametrised, handshaked successor to the single-cycle 4-bit processor datapath. It accepts one 16-bit instruction per transaction, reads an 8-entry register file of WIDTH-bit registers, and executes the ALU operation. Multiply, divide and modulus run as iterative multi-cycle units. Results are written back and presented on a valid/ready output channel. It sits between the pin-level instruction source and the result/flag output pins of the top level.

---
 rtl/alu_seq_core.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core
// Handshaked ALU datapath with an 8-entry register file. Single-cycle ops
// finish in one cycle. MUL (shift-add), DIV and MOD (restoring division) take
// WIDTH iterations in EXEC. Results are held on a valid/ready output channel.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        instruction channel, in_inst = {rd,rs1,rs2,func,opcode}
//   out_valid/out_ready      result channel
//   out_result               2*WIDTH result (zero-extended except MUL)
//   out_zero/carry/div0      result flags
//   busy                     block is not idle
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_inst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_zero,
  output logic               out_carry,
  output logic               out_div0,
  output logic               busy
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_ALU = 3'b011;

  localparam logic [3:0] F_AND  = 4'd0;
  localparam logic [3:0] F_OR   = 4'd1;
  localparam logic [3:0] F_XOR  = 4'd2;
  localparam logic [3:0] F_NAND = 4'd3;
  localparam logic [3:0] F_NOR  = 4'd4;
  localparam logic [3:0] F_XNOR = 4'd5;
  localparam logic [3:0] F_ADD  = 4'd6;
  localparam logic [3:0] F_SUB  = 4'd7;
  localparam logic [3:0] F_MUL  = 4'd8;
  localparam logic [3:0] F_DIV  = 4'd9;
  localparam logic [3:0] F_MOD  = 4'd10;
  localparam logic [3:0] F_LT   = 4'd11;
  localparam logic [3:0] F_GT   = 4'd12;
  localparam logic [3:0] F_EQ   = 4'd13;
  localparam logic [3:0] F_SHL  = 4'd14;
  localparam logic [3:0] F_SHR  = 4'd15;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;
  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_rf [8];

  // iterative unit context
  logic [3:0]       r_func;
  logic [2:0]       r_rd;
  logic             r_wb;
  logic [CW-1:0]    r_cnt;
  logic [W2-1:0]    r_acc, r_mcand;
  logic [WIDTH-1:0] r_mplier, r_quo, r_rem, r_dvs;

  // output registers
  logic [W2-1:0]    r_result;
  logic             r_zero, r_carry, r_div0;

  logic [2:0]       w_opcode, w_rs1, w_rs2, w_rd, w_rd_hi, w_it_rd_hi;
  logic [3:0]       w_func;
  logic [WIDTH-1:0] w_a, w_b, w_alu_lo;
  logic             w_alu_carry, w_alu_div0;
  logic             w_accept, w_is_alu, w_is_iter;
  logic [W2-1:0]    w_sc_res, w_it_res;
  logic             w_sc_carry, w_sc_div0, w_sc_wb, w_sc_wb_hi;
  logic [WIDTH:0]   w_div_shift, w_div_trial;

  assign w_opcode   = in_inst[2:0];
  assign w_func     = in_inst[6:3];
  assign w_rs2      = in_inst[9:7];
  assign w_rs1      = in_inst[12:10];
  assign w_rd       = in_inst[15:13];
  assign w_rd_hi    = w_rd + 3'd1;   // wraps r7 -> r0
  assign w_it_rd_hi = r_rd + 3'd1;
  assign w_a        = r_rf[w_rs1];
  assign w_b        = r_rf[w_rs2];
  assign w_accept   = in_valid & in_ready;
  assign w_is_alu   = (w_opcode == OP_ALU) || (w_opcode == OP_CMP);
  // a zero divisor/multiplier is resolved in one cycle
  assign w_is_iter  = w_is_alu && (w_b != '0) &&
                      ((w_func == F_MUL) || (w_func == F_DIV) || (w_func == F_MOD));

  // restoring division step: shift in the next dividend bit, try subtracting
  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_dvs};

  // single-cycle ALU result
  always_comb begin
    w_alu_lo    = '0;
    w_alu_carry = 1'b0;
    w_alu_div0  = 1'b0;
    case (w_func)
      F_AND:  w_alu_lo = w_a & w_b;
      F_OR:   w_alu_lo = w_a | w_b;
      F_XOR:  w_alu_lo = w_a ^ w_b;
      F_NAND: w_alu_lo = ~(w_a & w_b);
      F_NOR:  w_alu_lo = ~(w_a | w_b);
      F_XNOR: w_alu_lo = ~(w_a ^ w_b);
      F_ADD:  {w_alu_carry, w_alu_lo} = {1'b0, w_a} + {1'b0, w_b};
      F_SUB: begin
        w_alu_lo    = w_a - w_b;
        w_alu_carry = (w_a < w_b);
      end
      F_MUL:  w_alu_lo = '0;   // only reached with b == 0
      F_DIV: begin
        w_alu_lo   = '1;
        w_alu_div0 = (w_b == '0);
      end
      F_MOD: begin
        w_alu_lo   = w_a;
        w_alu_div0 = (w_b == '0);
      end
      F_LT:   w_alu_lo = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      F_GT:   w_alu_lo = {{(WIDTH-1){1'b0}}, (w_a > w_b)};
      F_EQ:   w_alu_lo = {{(WIDTH-1){1'b0}}, (w_a == w_b)};
      F_SHL: begin
        if (w_b >= SHIFT_LIM) w_alu_lo = '0;
        else                  w_alu_lo = w_a << w_b;
      end
      F_SHR: begin
        if (w_b >= SHIFT_LIM) w_alu_lo = '0;
        else                  w_alu_lo = w_a >> w_b;
      end
      default: w_alu_lo = '0;
    endcase
  end

  // opcode selection for the one-cycle path
  always_comb begin
    w_sc_res   = '0;
    w_sc_carry = 1'b0;
    w_sc_div0  = 1'b0;
    w_sc_wb    = 1'b0;
    w_sc_wb_hi = 1'b0;
    case (w_opcode)
      OP_ALU, OP_CMP: begin
        w_sc_res   = {{WIDTH{1'b0}}, w_alu_lo};
        w_sc_carry = w_alu_carry;
        w_sc_div0  = w_alu_div0;
        w_sc_wb    = (w_opcode == OP_ALU);
        w_sc_wb_hi = (w_opcode == OP_ALU) && (w_func == F_MUL);
      end
      OP_LDI: begin
        w_sc_res = {{WIDTH{1'b0}}, WIDTH'(in_inst[12:3])};
        w_sc_wb  = 1'b1;
      end
      default: w_sc_res = '0;
    endcase
  end

  // final result of the iterative unit
  always_comb begin
    case (r_func)
      F_MUL:   w_it_res = r_acc;
      F_DIV:   w_it_res = {{WIDTH{1'b0}}, r_quo};
      F_MOD:   w_it_res = {{WIDTH{1'b0}}, r_rem};
      default: w_it_res = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_is_iter ? S_EXEC : S_DONE;
        else          w_state_nxt = S_IDLE;
      end
      S_EXEC: begin
        if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
        else                   w_state_nxt = S_EXEC;
      end
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_is_iter ? S_EXEC : S_DONE;
        else if (out_ready) w_state_nxt = S_IDLE;
        else                w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // handshake/status outputs
  always_comb begin
    in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  // datapath: register file, iterative unit, output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= WIDTH'(i);
      r_func   <= 4'd0;
      r_rd     <= 3'd0;
      r_wb     <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_div0   <= 1'b0;
    end else if (w_accept) begin
      if (w_is_iter) begin
        r_func   <= w_func;
        r_rd     <= w_rd;
        r_wb     <= (w_opcode == OP_ALU);
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, w_a};
        r_mplier <= w_b;
        r_rem    <= '0;
        r_quo    <= w_a;
        r_dvs    <= w_b;
      end else begin
        r_result <= w_sc_res;
        r_zero   <= (w_sc_res == '0);
        r_carry  <= w_sc_carry;
        r_div0   <= w_sc_div0;
        if (w_sc_wb)    r_rf[w_rd]    <= w_sc_res[WIDTH-1:0];
        if (w_sc_wb_hi) r_rf[w_rd_hi] <= w_sc_res[W2-1:WIDTH];
      end
    end else if (r_state == S_EXEC) begin
      if (r_cnt == CNT_LAST) begin
        r_result <= w_it_res;
        r_zero   <= (w_it_res == '0);
        r_carry  <= 1'b0;
        r_div0   <= 1'b0;
        if (r_wb) r_rf[r_rd] <= w_it_res[WIDTH-1:0];
        if (r_wb && (r_func == F_MUL)) r_rf[w_it_rd_hi] <= w_it_res[W2-1:WIDTH];
      end else begin
        r_cnt    <= r_cnt + CW'(1);
        // both units step every cycle; r_func picks which result is used
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= {r_mcand[W2-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        if (!w_div_trial[WIDTH]) begin
          r_rem <= w_div_trial[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_div_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign out_result = r_result;
  assign out_zero   = r_zero;
  assign out_carry  = r_carry;
  assign out_div0   = r_div0;
endmodule
